// File: rtl/ucsbece154a_mc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ucsbece154a_mc_pkg                                               |
// | Purpose : Shared encodings for the multicycle RV32I controller: FSM        |
// |           states, opcode/funct3 constants, ALUOp, ALUControl, ResultSrc,   |
// |           ALUSrcA/B and ImmSrc selections.                                 |
// | Ports   : none (package)                                                   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package ucsbece154a_mc_pkg;

  // FETCH is encoded as zero so that the value shown on state_o while reset is
  // held (all outputs forced low) is also the state entered on release.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_IMMEXT    = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

endpackage
`default_nettype wire

// File: rtl/ucsbece154a_aludec.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ucsbece154a_aludec                                               |
// | Purpose : Combinational ALU decoder. Maps ALUOp/funct3/funct7b5/op[5] to   |
// |           the 3-bit ALU control and flags unsupported funct3 values.       |
// | Ports   : aluop_i[1:0], funct3_i[2:0], funct7b5_i, op5_i  -> inputs        |
// |           alucontrol_o[2:0], illegal_o                    -> outputs       |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module ucsbece154a_aludec
  import ucsbece154a_mc_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       op5_i,
  output logic [2:0] alucontrol_o,
  output logic       illegal_o
);

  always_comb begin
    alucontrol_o = ALU_ADD;
    illegal_o    = 1'b0;

    // The illegal flag looks at funct3 alone so the FSM can use it in DECODE,
    // before the ALU is actually steered by funct.
    case (funct3_i)
      F3_ADD, F3_SLT, F3_OR, F3_AND: illegal_o = 1'b0;
      default:                       illegal_o = 1'b1;
    endcase

    case (aluop_i)
      ALUOP_ADD: alucontrol_o = ALU_ADD;
      ALUOP_SUB: alucontrol_o = ALU_SUB;
      default: begin
        case (funct3_i)
          // op[5] separates R-type from I-type, so addi with bit30 set stays add
          F3_ADD:  alucontrol_o = (funct7b5_i & op5_i) ? ALU_SUB : ALU_ADD;
          F3_SLT:  alucontrol_o = ALU_SLT;
          F3_OR:   alucontrol_o = ALU_OR;
          F3_AND:  alucontrol_o = ALU_AND;
          default: alucontrol_o = ALU_ADD;
        endcase
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ucsbece154a_mc_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ucsbece154a_mc_controller                                        |
// | Purpose : Multicycle RV32I control FSM. Sequences fetch/decode/execute/    |
// |           writeback and drives the shared-memory datapath muxes/enables.   |
// | Params  : MEM_WAIT_EN (hold memory states on MemReady_i), EN_BNE, EN_LUI   |
// | Ports   : clk, reset_ni (sync, active low), op_i[6:0], funct3_i[2:0],      |
// |           funct7b5_i, Zero_i, MemReady_i -> inputs                         |
// |           PCWrite_o, AdrSrc_o, MemWrite_o, IRWrite_o, ResultSrc_o[1:0],    |
// |           ALUControl_o[2:0], ALUSrcA_o[1:0], ALUSrcB_o[1:0],               |
// |           ImmSrc_o[2:0], RegWrite_o, Illegal_o, state_o[3:0] -> outputs    |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module ucsbece154a_mc_controller
  import ucsbece154a_mc_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter bit EN_BNE      = 1'b1,
  parameter bit EN_LUI      = 1'b1
) (
  input  logic       clk,
  input  logic       reset_ni,
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       Zero_i,
  input  logic       MemReady_i,
  output logic       PCWrite_o,
  output logic       AdrSrc_o,
  output logic       MemWrite_o,
  output logic       IRWrite_o,
  output logic [1:0] ResultSrc_o,
  output logic [2:0] ALUControl_o,
  output logic [1:0] ALUSrcA_o,
  output logic [1:0] ALUSrcB_o,
  output logic [2:0] ImmSrc_o,
  output logic       RegWrite_o,
  output logic       Illegal_o,
  output logic [3:0] state_o
);

  state_t     state_q, state_d;
  aluop_t     w_aluop;
  logic [2:0] w_alucontrol;
  logic       w_funct_ill;
  logic       w_ready;

  // With the handshake disabled every memory access completes in one cycle.
  assign w_ready = MemReady_i | ~MEM_WAIT_EN;

  always_ff @(posedge clk) begin
    if (!reset_ni) state_q <= S_FETCH;
    else           state_q <= state_d;
  end

  always_comb begin
    w_aluop = ALUOP_ADD;
    case (state_q)
      S_EXECR, S_EXECI: w_aluop = ALUOP_FUNCT;
      S_BRANCH:         w_aluop = ALUOP_SUB;
      default:          w_aluop = ALUOP_ADD;
    endcase
  end

  ucsbece154a_aludec u_aludec (
    .aluop_i      (w_aluop),
    .funct3_i     (funct3_i),
    .funct7b5_i   (funct7b5_i),
    .op5_i        (op_i[5]),
    .alucontrol_o (w_alucontrol),
    .illegal_o    (w_funct_ill)
  );

  assign ALUControl_o = reset_ni ? w_alucontrol : 3'b000;
  assign state_o      = reset_ni ? state_q : S_FETCH;

  always_comb begin
    state_d     = state_q;
    PCWrite_o   = 1'b0;
    AdrSrc_o    = 1'b0;
    MemWrite_o  = 1'b0;
    IRWrite_o   = 1'b0;
    ResultSrc_o = RES_ALUOUT;
    ALUSrcA_o   = SRCA_PC;
    ALUSrcB_o   = SRCB_RD2;
    ImmSrc_o    = IMM_I;
    RegWrite_o  = 1'b0;
    Illegal_o   = 1'b0;

    case (state_q)
      S_FETCH: begin
        ALUSrcB_o   = SRCB_FOUR;
        ResultSrc_o = RES_ALURESULT;
        IRWrite_o   = w_ready;
        PCWrite_o   = w_ready;
        if (w_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Branch target OldPC+imm is precomputed here into ALUOut.
        ALUSrcA_o = SRCA_OLDPC;
        ALUSrcB_o = SRCB_IMM;
        ImmSrc_o  = IMM_B;
        case (op_i)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE: begin
            state_d   = w_funct_ill ? S_FETCH : S_EXECR;
            Illegal_o = w_funct_ill;
          end
          OP_ITYPE: begin
            state_d   = w_funct_ill ? S_FETCH : S_EXECI;
            Illegal_o = w_funct_ill;
          end
          OP_BRANCH: begin
            if (funct3_i == F3_BEQ || (EN_BNE && funct3_i == F3_BNE)) begin
              state_d = S_BRANCH;
            end else begin
              state_d   = S_FETCH;
              Illegal_o = 1'b1;
            end
          end
          OP_JAL: state_d = S_JAL;
          OP_LUI: begin
            if (EN_LUI) begin
              state_d = S_LUI;
            end else begin
              state_d   = S_FETCH;
              Illegal_o = 1'b1;
            end
          end
          default: begin
            state_d   = S_FETCH;
            Illegal_o = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA_o = SRCA_RD1;
        ALUSrcB_o = SRCB_IMM;
        ImmSrc_o  = (op_i == OP_LW) ? IMM_I : IMM_S;
        state_d   = (op_i == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc_o = 1'b1;
        if (w_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc_o = RES_DATA;
        RegWrite_o  = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWRITE: begin
        // Strobe stays asserted through the whole wait.
        AdrSrc_o   = 1'b1;
        MemWrite_o = 1'b1;
        if (w_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA_o = SRCA_RD1;
        ALUSrcB_o = SRCB_RD2;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA_o = SRCA_RD1;
        ALUSrcB_o = SRCB_IMM;
        ImmSrc_o  = IMM_I;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite_o = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA_o = SRCA_RD1;
        ALUSrcB_o = SRCB_RD2;
        // Only beq and (when enabled) bne reach this state.
        PCWrite_o = (funct3_i == F3_BEQ) ? Zero_i : ~Zero_i;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        // Link value PC+4 is formed from OldPC and written back in ALUWB.
        ALUSrcA_o = SRCA_OLDPC;
        ALUSrcB_o = SRCB_FOUR;
        PCWrite_o = 1'b1;
        state_d   = S_ALUWB;
      end
      S_LUI: begin
        ImmSrc_o    = IMM_U;
        ResultSrc_o = RES_IMMEXT;
        RegWrite_o  = 1'b1;
        state_d     = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    if (!reset_ni) begin
      PCWrite_o   = 1'b0;
      AdrSrc_o    = 1'b0;
      MemWrite_o  = 1'b0;
      IRWrite_o   = 1'b0;
      ResultSrc_o = 2'b00;
      ALUSrcA_o   = 2'b00;
      ALUSrcB_o   = 2'b00;
      ImmSrc_o    = 3'b000;
      RegWrite_o  = 1'b0;
      Illegal_o   = 1'b0;
    end
  end

endmodule
`default_nettype wire
